wb_arbiter2: RTL

Two-master, one-slave Wishbone arbiter that shares a single on-chip slave (boot ROM, RAM or a peripheral window) between two requesters, typically CPU instruction fetch (m0) and data port/debug DMA (m1). Round-robin grant, held for the whole `cyc` burst. A per-access watchdog terminates stalled accesses with an error so a missing slave can never hang a master. Sits between the masters and the slave's `WISHBONE_SLAVE` port in the SoC interconnect.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_watchdog.sv | 47 ++++
 rtl/wb_arbiter2.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_pkg                                                                   |
// | Shared Wishbone interconnect types: arbiter state encoding, helpers.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TMO   = 2'd2
    } wb_state_e;

    // A zero timeout still needs a legal (unused) counter width.
    function automatic int wd_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_watchdog                                                              |
// | Counts consecutive stalled strobe cycles and pulses o_expire on the      |
// | TIMEOUT-th one. TIMEOUT = 0 disables the watchdog.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic i_stall,
    output logic o_expire
);

    generate
        if (TIMEOUT > 0) begin : g_wd_on
            localparam int                 c_WDW  = wd_width(TIMEOUT);
            localparam logic [c_WDW-1:0]   c_LAST = c_WDW'(TIMEOUT - 1);

            logic [c_WDW-1:0] r_wd;
            logic             w_hit;

            assign w_hit    = i_stall && (r_wd == c_LAST);
            assign o_expire = w_hit;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    r_wd <= '0;
                end else if (!i_stall || w_hit) begin
                    r_wd <= '0;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end
        end else begin : g_wd_off
            logic w_unused;
            assign w_unused = i_stall ^ sys_clk ^ sys_rst;
            assign o_expire = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter2                                                              |
// | Two-master / one-slave Wishbone arbiter, round-robin, grant held for the |
// | whole cyc burst, watchdog errors stalled accesses.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,

    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_adr,
    input  logic [DATA_WIDTH-1:0]   m0_mosi,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    output logic [DATA_WIDTH-1:0]   m0_miso,
    output logic                    m0_ack,
    output logic                    m0_err,

    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_adr,
    input  logic [DATA_WIDTH-1:0]   m1_mosi,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    output logic [DATA_WIDTH-1:0]   m1_miso,
    output logic                    m1_ack,
    output logic                    m1_err,

    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_WIDTH-1:0]   s_adr,
    output logic [DATA_WIDTH-1:0]   s_mosi,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    input  logic [DATA_WIDTH-1:0]   s_miso,
    input  logic                    s_ack,
    input  logic                    s_err
);

    wb_state_e r_state, w_state_nxt;
    logic      r_owner, w_owner_nxt;
    logic      r_last,  w_last_nxt;

    logic      w_own_cyc;
    logic      w_stall;
    logic      w_expire;
    logic      w_rsp_ack;
    logic      w_rsp_err;

    assign w_own_cyc = r_owner ? m1_cyc : m0_cyc;
    assign w_stall   = (r_state == ST_GRANT) && s_cyc && s_stb && !s_ack && !s_err;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .i_stall  (w_stall),
        .o_expire (w_expire)
    );

    // last resets to 1 so that m0 wins the first tie.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    w_owner_nxt = ~r_last;
                    w_state_nxt = ST_GRANT;
                end else if (m0_cyc) begin
                    w_owner_nxt = 1'b0;
                    w_state_nxt = ST_GRANT;
                end else if (m1_cyc) begin
                    w_owner_nxt = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!w_own_cyc) begin
                    w_last_nxt  = r_owner;
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = ST_TMO;
                end
            end
            ST_TMO: begin
                if (w_own_cyc) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_last_nxt  = r_owner;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Slave request follows the owner combinationally; TMO masks stb and
    // substitutes an arbiter-generated error for the slave response.
    assign w_rsp_ack = (r_state == ST_GRANT) && s_ack;
    assign w_rsp_err = (r_state == ST_GRANT) ? s_err : 1'b1;

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_mosi  = '0;
        s_sel   = '0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m0_miso = '0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        m1_miso = '0;
        if (r_state != ST_IDLE) begin
            s_cyc  = w_own_cyc;
            s_stb  = (r_state == ST_GRANT) && (r_owner ? m1_stb : m0_stb);
            s_we   = r_owner ? m1_we   : m0_we;
            s_adr  = r_owner ? m1_adr  : m0_adr;
            s_mosi = r_owner ? m1_mosi : m0_mosi;
            s_sel  = r_owner ? m1_sel  : m0_sel;
            if (r_owner) begin
                m1_ack  = w_rsp_ack;
                m1_err  = w_rsp_err;
                m1_miso = s_miso;
            end else begin
                m0_ack  = w_rsp_ack;
                m0_err  = w_rsp_err;
                m0_miso = s_miso;
            end
        end
    end

endmodule
`default_nettype wire
